// File: rtl/refcpu_bus_arbiter.sv
// RefCPU ibus/dbus arbiter: one downstream memory port, one outstanding
// transaction, grant locked until completion, sticky watchdog flag.
module refcpu_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int TIMEOUT     = 1023
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_valid,
    input  logic [AW-1:0]   i_addr,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [DW-1:0]   i_data,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_strobe,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [DW-1:0]   d_data,
    output logic            m_valid,
    output logic [AW-1:0]   m_addr,
    output logic [DW/8-1:0] m_strobe,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata,
    output logic            grant_d,
    output logic            timeout_err
);

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TW = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    logic          owner_d;
    logic          last_d;
    logic [WW-1:0] wdog;
    logic [WW-1:0] wdog_nx;
    logic          pick_d;
    logic          in_req;
    logic          in_wait;
    logic          done;

    // Tie-break: fixed priority favours D, round-robin favours the one not served last.
    always_comb begin
        pick_d = d_valid;
        if (i_valid && d_valid) begin
            pick_d = ROUND_ROBIN ? ~last_d : 1'b1;
        end
    end

    assign in_req  = (state == REQ);
    assign in_wait = (state == WAIT);
    assign done    = (in_req && m_addr_ok && m_data_ok) ||
                     (in_wait && m_data_ok);
    assign wdog_nx = wdog + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            last_d      <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid || d_valid) begin
                        owner_d <= pick_d;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (m_addr_ok) begin
                        state <= m_data_ok ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done) begin
                last_d <= owner_d;
            end

            // Flag is raised as the count reaches TIMEOUT, so it is visible
            // in the (TIMEOUT+1)-th busy cycle; the count then holds.
            if (state == IDLE) begin
                wdog <= '0;
            end else if (TIMEOUT != 0 && wdog != TW) begin
                wdog <= wdog_nx;
                if (wdog_nx == TW) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    assign m_valid   = in_req;
    assign m_addr    = owner_d ? d_addr : i_addr;
    assign m_strobe  = owner_d ? d_strobe : '0;
    assign m_wdata   = owner_d ? d_wdata : '0;

    assign i_addr_ok = in_req && !owner_d && m_addr_ok;
    assign d_addr_ok = in_req && owner_d && m_addr_ok;
    assign i_data_ok = done && !owner_d;
    assign d_data_ok = done && owner_d;

    assign i_data    = m_rdata;
    assign d_data    = m_rdata;
    assign grant_d   = owner_d;

endmodule

// File: tb/tb_refcpu_bus_arbiter.sv
// Bench for refcpu_bus_arbiter: vector table of single transactions plus
// hand sequences for ties, locking, watchdog and mid-transaction reset.
module tb_refcpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, d_valid, ri_valid, rd_valid;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_strobe;
    logic        m_addr_ok, m_data_ok;

    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_data, d_data, m_addr, m_wdata;
    logic [3:0]  m_strobe;
    logic        m_valid, grant_d, timeout_err;

    logic        r_i_addr_ok, r_i_data_ok, r_d_addr_ok, r_d_data_ok;
    logic [31:0] r_i_data, r_d_data, r_m_addr, r_m_wdata;
    logic [3:0]  r_m_strobe;
    logic        r_m_valid, r_grant_d, r_timeout_err;

    always #5 clk = ~clk;

    refcpu_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_data(d_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .grant_d(grant_d), .timeout_err(timeout_err)
    );

    refcpu_bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .i_valid(ri_valid), .i_addr(i_addr), .i_addr_ok(r_i_addr_ok),
        .i_data_ok(r_i_data_ok), .i_data(r_i_data),
        .d_valid(rd_valid), .d_addr(d_addr), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(r_d_addr_ok), .d_data_ok(r_d_data_ok),
        .d_data(r_d_data),
        .m_valid(r_m_valid), .m_addr(r_m_addr), .m_strobe(r_m_strobe),
        .m_wdata(r_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .grant_d(r_grant_d),
        .timeout_err(r_timeout_err)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          hold;
        int          lat;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[4];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Settle mid-cycle, then retire any data_ok against the scoreboard.
    task automatic samp();
        exp_t e;
        #2;
        if (i_data_ok || d_data_ok) begin
            nchk++;
            if (sbq.size() == 0 || (i_data_ok && d_data_ok)) begin
                nerr++;
                $display("FAIL sb_spurious: i_ok=%0b d_ok=%0b queued=%0d, expected no data_ok",
                         i_data_ok, d_data_ok, sbq.size());
            end else begin
                e = sbq.pop_front();
                if (d_data_ok !== e.is_d ||
                    (d_data_ok ? d_data : i_data) !== e.data) begin
                    nerr++;
                    $display("FAIL sb_data: got d=%0b data=%0h expected d=%0b data=%0h",
                             d_data_ok, d_data_ok ? d_data : i_data,
                             e.is_d, e.data);
                end
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic idle_bus();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        i_addr   = v.is_d ? 32'h0BAD0000 : v.addr;
        d_addr   = v.is_d ? v.addr : 32'h0BAD0004;
        d_strobe = v.strb;
        d_wdata  = v.wdata;
        i_valid  = !v.is_d;
        d_valid  = v.is_d;
        idle_bus();
        samp();
        chk("v_arb_mvalid", m_valid, 0);
        nxt();
        for (int h = 0; h < v.hold; h++) begin
            samp();
            chk("v_hold_mvalid", m_valid, 1);
            chk("v_hold_strobe", m_strobe, v.exp_strb);
            chk("v_hold_wdata", m_wdata, v.exp_wdata);
            chk("v_hold_aok", i_addr_ok | d_addr_ok, 0);
            nxt();
        end
        m_addr_ok = 1'b1;
        m_data_ok = (v.lat == 0);
        m_rdata   = (v.lat == 0) ? v.rdata : 32'h0;
        if (v.lat == 0) push(v.is_d, v.rdata);
        samp();
        chk("v_req_mvalid", m_valid, 1);
        chk("v_req_addr", m_addr, v.addr);
        chk("v_req_strobe", m_strobe, v.exp_strb);
        chk("v_req_wdata", m_wdata, v.exp_wdata);
        chk("v_req_grant", grant_d, v.is_d);
        chk("v_req_aok", {i_addr_ok, d_addr_ok}, {!v.is_d, v.is_d});
        nxt();
        m_addr_ok = 1'b0;
        for (int k = 1; k <= v.lat; k++) begin
            m_data_ok = (k == v.lat);
            m_rdata   = (k == v.lat) ? v.rdata : 32'h0;
            if (k == v.lat) push(v.is_d, v.rdata);
            samp();
            chk("v_wait_mvalid", m_valid, 0);
            nxt();
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        idle_bus();
        samp();
        chk("v_done_mvalid", m_valid, 0);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 32'hBFC00000, 4'hF, 32'h11111111, 32'h24020001,
                   0, 2, 4'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h80001000, 4'b0011, 32'hDEADBEEF, 32'h0,
                   2, 0, 4'b0011, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h80002000, 4'h0, 32'h0, 32'hCAFEF00D,
                   1, 1, 4'h0, 32'h0};
        tbl[3] = '{1'b0, 32'h00000040, 4'h0, 32'h0, 32'h12345678,
                   0, 0, 4'h0, 32'h0};

        resetn = 1'b0;
        {i_valid, d_valid, ri_valid, rd_valid} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_strobe = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        samp();
        chk("reset_outs",
            {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok,
             grant_d, timeout_err}, 0);
        resetn = 1'b1;
        nxt();

        for (int n = 0; n < 4; n++) run_vec(tbl[n]);

        // Tie with fixed priority: D first, then I, with an idle cycle between.
        i_addr = 32'hBFC00100; d_addr = 32'h80003000; d_strobe = 4'h0;
        i_valid = 1'b1; d_valid = 1'b1;
        samp(); nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hD0D0D0D0;
        push(1'b1, 32'hD0D0D0D0);
        samp();
        chk("tie_grant_d", grant_d, 1);
        chk("tie_addr_d", m_addr, 32'h80003000);
        chk("tie_i_aok", i_addr_ok, 0);
        nxt();
        d_valid = 1'b0; idle_bus();
        samp();
        chk("tie_gap_mvalid", m_valid, 0);
        nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1A1A1A1A;
        push(1'b0, 32'h1A1A1A1A);
        samp();
        chk("tie_grant_i", grant_d, 0);
        chk("tie_addr_i", m_addr, 32'hBFC00100);
        nxt();
        i_valid = 1'b0; idle_bus();
        samp(); nxt();

        // Round-robin instance: after a D transaction a tie goes to I.
        d_wdata = 32'h5A5A5A5A;
        rd_valid = 1'b1;
        samp(); nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0;
        samp();
        chk("rr_first_d", {r_grant_d, r_d_data_ok}, 2'b11);
        nxt();
        rd_valid = 1'b0; idle_bus();
        samp(); nxt();
        ri_valid = 1'b1; rd_valid = 1'b1;
        samp(); nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h77776666;
        samp();
        chk("rr_tie_grant", r_grant_d, 0);
        chk("rr_tie_addr", r_m_addr, 32'hBFC00100);
        chk("rr_tie_ok", {r_m_valid, r_i_addr_ok, r_i_data_ok, r_d_data_ok,
                          r_m_strobe}, {4'b1110, 4'h0});
        chk("rr_tie_data", r_i_data, 32'h77776666);
        nxt();
        ri_valid = 1'b0; idle_bus();
        samp(); nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h99998888;
        samp();
        chk("rr_then_d", {r_grant_d, r_d_addr_ok, r_d_data_ok}, 3'b111);
        chk("rr_d_data", r_d_data, 32'h99998888);
        chk("rr_d_wdata", r_m_wdata, 32'h5A5A5A5A);
        chk("rr_no_to", r_timeout_err, 0);
        nxt();
        rd_valid = 1'b0; idle_bus();
        samp(); nxt();

        // Spurious completions with nobody granted.
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hBADBAD00;
        samp();
        chk("spur_oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        nxt();
        idle_bus();
        samp();
        chk("spur_stay_idle", m_valid, 0);
        nxt();

        // D arrives while I owns; I drops valid mid-transaction.
        i_addr = 32'h00001000; i_valid = 1'b1;
        samp(); nxt();
        d_addr = 32'h80004000; d_strobe = 4'h0; d_valid = 1'b1;
        samp();
        chk("lock_grant", grant_d, 0);
        chk("lock_addr", m_addr, 32'h00001000);
        nxt();
        m_addr_ok = 1'b1;
        samp();
        chk("lock_aok", {i_addr_ok, d_addr_ok}, 2'b10);
        nxt();
        m_addr_ok = 1'b0; i_valid = 1'b0;
        samp();
        chk("lock_wait", {m_valid, d_data_ok}, 0);
        nxt();
        m_data_ok = 1'b1; m_rdata = 32'hABCD0001;
        push(1'b0, 32'hABCD0001);
        samp(); nxt();
        idle_bus();
        samp();
        chk("lock_gap", m_valid, 0);
        nxt();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hABCD0002;
        push(1'b1, 32'hABCD0002);
        samp();
        chk("lock_d_grant", grant_d, 1);
        chk("lock_d_addr", m_addr, 32'h80004000);
        nxt();
        d_valid = 1'b0; idle_bus();
        samp(); nxt();

        // Watchdog with TIMEOUT=8: flag appears in the 9th busy cycle.
        i_addr = 32'h00002000; i_valid = 1'b1;
        samp(); nxt();
        for (int c = 1; c <= 13; c++) begin
            m_addr_ok = (c == 1);
            m_data_ok = (c == 13);
            m_rdata   = (c == 13) ? 32'h0BEEF000 : 32'h0;
            if (c == 13) push(1'b0, 32'h0BEEF000);
            samp();
            if (c == 1) chk("to_start", timeout_err, 0);
            if (c == 8) chk("to_cycle8", timeout_err, 0);
            if (c == 9) chk("to_cycle9", timeout_err, 1);
            if (c == 12) chk("to_wait_mvalid", m_valid, 0);
            if (c == 13) chk("to_cycle13", timeout_err, 1);
            nxt();
        end
        i_valid = 1'b0; idle_bus();
        samp();
        chk("to_sticky", {timeout_err, m_valid}, 2'b10);
        nxt();

        // Reset while in WAIT.
        i_addr = 32'h00003000; i_valid = 1'b1;
        samp(); nxt();
        m_addr_ok = 1'b1;
        samp(); nxt();
        m_addr_ok = 1'b0; i_valid = 1'b0; resetn = 1'b0;
        samp(); nxt();
        samp();
        chk("rst_outs",
            {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok,
             grant_d, timeout_err}, 0);
        resetn = 1'b1;
        nxt();
        run_vec(tbl[0]);

        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
